// File: rtl/wdg_regif_if.sv
// Register-bus bundle for the watchdog register interface.
// Single-cycle request/acknowledge: the master holds req/we/addr/wdata for one
// cycle, the slave answers with ack and rdata on the following cycle.
interface wdg_regif_if;
   logic        req;
   logic        we;
   logic [3:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ack;

   modport master (
      output req,
      output we,
      output addr,
      output wdata,
      input  rdata,
      input  ack
   );

   modport slave (
      input  req,
      input  we,
      input  addr,
      input  wdata,
      output rdata,
      output ack
   );
endinterface

// File: rtl/wdg_regif.sv
// Watchdog register interface: CTRL/TIMEOUT/STATUS/COUNT registers, the
// timeout down-counter, sticky stage status with software service pulses.
// Optional feature macro: WDG_LOCK_EN -- when defined, writing CTRL.LOCK=1
// freezes CTRL and TIMEOUT until reset (STATUS W1C keeps working).
//
// Register map (addr[3:2]):
//   0x0 CTRL    bit0 EN, bit1 LOCK
//   0x4 TIMEOUT CNT_W bits, read/write
//   0x8 STATUS  bit0 S1, bit1 S2, sticky, write-1-to-clear
//   0xC COUNT   read-only current counter
module wdg_regif #(
   parameter int CNT_W = 32
) (
   input  logic          clk,
   input  logic          res_n,
   wdg_regif_if.slave    bus,
   output logic          en,
   output logic          count0,
   input  logic          do_cnt,
   input  logic          s1wto,
   input  logic          s2wto,
   output logic          sw_trg_s1wto,
   output logic          sw_trg_s2wto,
   output logic          irq,
   output logic          rst_req
);

   localparam logic [1:0] SEL_CTRL    = 2'd0;
   localparam logic [1:0] SEL_TIMEOUT = 2'd1;
   localparam logic [1:0] SEL_STATUS  = 2'd2;
   localparam logic [1:0] SEL_COUNT   = 2'd3;

   // 16'hFFFF zero-extended or truncated to the counter width.
   localparam logic [CNT_W-1:0] TIMEOUT_RST = CNT_W'(32'h0000_FFFF);

   logic [CNT_W-1:0] timeout;
   logic [CNT_W-1:0] cnt;
   logic             lock;
   logic             st_s1;
   logic             st_s2;
   logic [1:0]       sel;
   logic             wr;
   logic             rd;
   logic             cfg_wr_ok;
   logic             clr_s1;
   logic             clr_s2;
   logic [31:0]      rd_mux;
   logic             unused_addr;

   assign sel         = bus.addr[3:2];
   assign wr          = bus.req & bus.we;
   assign rd          = bus.req & ~bus.we;
   assign unused_addr = &{1'b0, bus.addr[1:0]};

   assign clr_s1 = wr & (sel == SEL_STATUS) & bus.wdata[0];
   assign clr_s2 = wr & (sel == SEL_STATUS) & bus.wdata[1];

`ifdef WDG_LOCK_EN
   assign cfg_wr_ok = ~lock;

   // Lock bit: once set it can only be cleared by reset.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         lock <= 1'b0;
      end else if (wr && (sel == SEL_CTRL) && cfg_wr_ok && bus.wdata[1]) begin
         lock <= 1'b1;
      end
   end
`else
   assign cfg_wr_ok = 1'b1;
   assign lock      = 1'b0;
`endif

   // CTRL.EN and TIMEOUT configuration registers.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         en      <= 1'b0;
         timeout <= TIMEOUT_RST;
      end else if (wr && cfg_wr_ok) begin
         if (sel == SEL_CTRL) begin
            en <= bus.wdata[0];
         end
         if (sel == SEL_TIMEOUT) begin
            timeout <= bus.wdata[CNT_W-1:0];
         end
      end
   end

   // Down-counter: reload whenever idle, count to zero and hold there.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         cnt <= TIMEOUT_RST;
      end else if (!do_cnt) begin
         cnt <= timeout;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign count0 = do_cnt & (cnt == '0);

   // Sticky stage status; a hardware set in the same cycle beats the W1C.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         st_s1 <= 1'b0;
         st_s2 <= 1'b0;
      end else begin
         st_s1 <= s1wto | (st_s1 & ~clr_s1);
         st_s2 <= s2wto | (st_s2 & ~clr_s2);
      end
   end

   assign irq     = st_s1 | st_s2;
   assign rst_req = s2wto;

   // Read data selection from the register state seen at the request edge.
   always_comb begin
      rd_mux = '0;
      case (sel)
         SEL_CTRL:    rd_mux[1:0]       = {lock, en};
         SEL_TIMEOUT: rd_mux[CNT_W-1:0] = timeout;
         SEL_STATUS:  rd_mux[1:0]       = {st_s2, st_s1};
         SEL_COUNT:   rd_mux[CNT_W-1:0] = cnt;
         default:     rd_mux            = '0;
      endcase
   end

   // Bus response: ack, read data and service pulses all land one cycle after req.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         bus.ack      <= 1'b0;
         bus.rdata    <= '0;
         sw_trg_s1wto <= 1'b0;
         sw_trg_s2wto <= 1'b0;
      end else begin
         bus.ack      <= bus.req;
         bus.rdata    <= rd ? rd_mux : 32'h0;
         sw_trg_s1wto <= clr_s1;
         sw_trg_s2wto <= clr_s2;
      end
   end

endmodule

// File: tb/tb_wdg_regif.sv
// Directed bench for wdg_regif: reset values, counter timing, status
// service/collision behaviour, CTRL lock and mid-access reset.
module tb_wdg_regif;

   logic clk = 1'b0;
   logic res_n;
   logic en, count0, do_cnt, s1wto, s2wto;
   logic sw_trg_s1wto, sw_trg_s2wto, irq, rst_req;
   logic [31:0] rd_val;
   int checks   = 0;
   int failures = 0;

   wdg_regif_if bus ();

   wdg_regif #(.CNT_W(32)) dut (
      .clk          (clk),
      .res_n        (res_n),
      .bus          (bus),
      .en           (en),
      .count0       (count0),
      .do_cnt       (do_cnt),
      .s1wto        (s1wto),
      .s2wto        (s2wto),
      .sw_trg_s1wto (sw_trg_s1wto),
      .sw_trg_s2wto (sw_trg_s2wto),
      .irq          (irq),
      .rst_req      (rst_req)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
      bus.req   = 1'b1;
      bus.we    = 1'b1;
      bus.addr  = a;
      bus.wdata = d;
      step();
      check("wr_ack", {31'b0, bus.ack}, 32'd1);
      bus.req = 1'b0;
      bus.we  = 1'b0;
   endtask

   task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
      bus.req  = 1'b1;
      bus.we   = 1'b0;
      bus.addr = a;
      step();
      check("rd_ack", {31'b0, bus.ack}, 32'd1);
      d = bus.rdata;
      bus.req = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      res_n     = 1'b0;
      bus.req   = 1'b0;
      bus.we    = 1'b0;
      bus.addr  = 4'h0;
      bus.wdata = 32'h0;
      do_cnt    = 1'b0;
      s1wto     = 1'b0;
      s2wto     = 1'b0;
      repeat (3) step();
      check("rst_ack", {31'b0, bus.ack}, 32'd0);
      check("rst_rdata", bus.rdata, 32'h0);
      res_n = 1'b1;
      check("rst_en", {31'b0, en}, 32'd0);
      check("rst_irq", {31'b0, irq}, 32'd0);

      // Reset values
      bus_read(4'h4, rd_val); check("rst_timeout", rd_val, 32'h0000_FFFF);
      bus_read(4'h0, rd_val); check("rst_ctrl", rd_val, 32'h0);
      bus_read(4'h8, rd_val); check("rst_status", rd_val, 32'h0);
      bus_read(4'hC, rd_val); check("rst_count", rd_val, 32'h0000_FFFF);
      step();
      check("idle_ack", {31'b0, bus.ack}, 32'd0);
      check("idle_rdata", bus.rdata, 32'h0);

      // TIMEOUT write/readback, COUNT write ignored
      bus_write(4'h4, 32'd5);
      bus_read(4'h4, rd_val); check("timeout_rb", rd_val, 32'd5);
      bus_write(4'hC, 32'h77);
      bus_read(4'hD, rd_val); check("count_ro", rd_val, 32'd5);

      // Count: back-to-back COUNT reads while counting down from 5
      do_cnt   = 1'b1;
      bus.req  = 1'b1;
      bus.we   = 1'b0;
      bus.addr = 4'hC;
      #1;
      check("cnt_c0_start", {31'b0, count0}, 32'd0);
      for (int k = 1; k <= 6; k++) begin
         step();
         check("cnt_b2b_ack", {31'b0, bus.ack}, 32'd1);
         check("cnt_value", bus.rdata, 32'(6 - k));
         check("cnt_count0", {31'b0, count0}, (k >= 5) ? 32'd1 : 32'd0);
      end
      step();
      check("cnt_hold0", bus.rdata, 32'd0);
      bus.req = 1'b0;
      do_cnt  = 1'b0;
      step();
      check("cnt_reload_c0", {31'b0, count0}, 32'd0);

      // New TIMEOUT does not disturb a running count
      do_cnt = 1'b1;
      bus_write(4'h4, 32'd9);
      bus_read(4'hC, rd_val); check("to_inflight", rd_val, 32'd4);
      do_cnt = 1'b0;
      step();
      bus_read(4'hC, rd_val); check("to_next_reload", rd_val, 32'd9);

      // TIMEOUT = 0: count0 in the first do_cnt cycle
      bus_write(4'h4, 32'd0);
      step();
      do_cnt = 1'b1;
      #1;
      check("to0_count0", {31'b0, count0}, 32'd1);
      do_cnt = 1'b0;
      step();

      // Service stage 1
      s1wto = 1'b1;
      step();
      s1wto = 1'b0;
      check("s1_irq", {31'b0, irq}, 32'd1);
      bus_read(4'h8, rd_val); check("s1_status", rd_val, 32'h1);
      bus_write(4'h8, 32'h1);
      check("s1_trg", {30'b0, sw_trg_s2wto, sw_trg_s1wto}, 32'h1);
      check("s1_irq_clr", {31'b0, irq}, 32'd0);
      step();
      check("s1_trg_end", {30'b0, sw_trg_s2wto, sw_trg_s1wto}, 32'h0);
      bus_read(4'h8, rd_val); check("s1_status_clr", rd_val, 32'h0);

      // Stage 2 set, W1C with no bits selected does nothing
      s2wto = 1'b1;
      #1;
      check("rst_req_on", {31'b0, rst_req}, 32'd1);
      step();
      s2wto = 1'b0;
      #1;
      check("rst_req_off", {31'b0, rst_req}, 32'd0);
      bus_write(4'h8, 32'h0);
      check("noop_trg", {30'b0, sw_trg_s2wto, sw_trg_s1wto}, 32'h0);
      bus_read(4'h8, rd_val); check("noop_status", rd_val, 32'h2);
      bus_write(4'h8, 32'h2);
      check("s2_trg", {30'b0, sw_trg_s2wto, sw_trg_s1wto}, 32'h2);
      bus_read(4'h8, rd_val); check("s2_status_clr", rd_val, 32'h0);

      // Collision: hardware set wins over W1C, pulse still emitted
      s2wto = 1'b1;
      bus_write(4'h8, 32'h2);
      s2wto = 1'b0;
      check("col_trg", {30'b0, sw_trg_s2wto, sw_trg_s1wto}, 32'h2);
      bus_read(4'h8, rd_val); check("col_status", rd_val, 32'h2);
      check("col_irq", {31'b0, irq}, 32'd1);

      // CTRL / lock
      bus_write(4'h0, 32'h3);
      check("ctrl_en", {31'b0, en}, 32'd1);
      bus_read(4'h0, rd_val);
`ifdef WDG_LOCK_EN
      check("ctrl_rb", rd_val, 32'h3);
`else
      check("ctrl_rb", rd_val, 32'h1);
`endif
      bus_write(4'h0, 32'h0);
      bus_write(4'h4, 32'h33);
      bus_read(4'h4, rd_val);
`ifdef WDG_LOCK_EN
      check("lock_en", {31'b0, en}, 32'd1);
      check("lock_timeout", rd_val, 32'h0);
`else
      check("nolock_en", {31'b0, en}, 32'd0);
      check("nolock_timeout", rd_val, 32'h33);
`endif

      // Mid-access reset aborts the write
      bus.req   = 1'b1;
      bus.we    = 1'b1;
      bus.addr  = 4'h4;
      bus.wdata = 32'h10;
      res_n     = 1'b0;
      step();
      check("mid_ack", {31'b0, bus.ack}, 32'd0);
      check("mid_trg", {30'b0, sw_trg_s2wto, sw_trg_s1wto}, 32'h0);
      bus.req = 1'b0;
      bus.we  = 1'b0;
      #2;
      res_n = 1'b1;
      check("mid_en", {31'b0, en}, 32'd0);
      bus_read(4'h4, rd_val); check("mid_timeout", rd_val, 32'h0000_FFFF);
      bus_read(4'h8, rd_val); check("mid_status", rd_val, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
